// File: rtl/alu_bist.sv
// Self-test engine for the 4-bit ALU.
// Drives deterministic vectors and checks Z against a golden model.
module alu_bist #(
  parameter int               WIDTH     = 4,
  parameter int               NUM_PAIRS = 4,
  parameter logic [WIDTH-1:0] A0        = 4'b1001,
  parameter logic [WIDTH-1:0] B0        = 4'b0101
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_s,
  output logic               alu_en,
  input  logic [WIDTH-1:0]   alu_z,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_cnt,
  output logic [2*WIDTH+3:0] err_vec
);

  localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [PW-1:0]    pair;
  logic [3:0]       vec;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] gold;
  logic             last;
  logic             mismatch;

  assign last     = (pair == PW'(NUM_PAIRS - 1)) && (vec == 4'hf);
  assign mismatch = (alu_z != gold);
  assign busy     = (state == ST_DRIVE) || (state == ST_CHECK);

  // Golden ALU result for the vector currently on the ALU inputs
  always_comb begin
    gold = '0;
    if (alu_en) begin
      unique case (alu_s)
        3'b000: gold = alu_a + alu_b;
        3'b001: gold = alu_a - alu_b;
        3'b010: gold = alu_a & alu_b;
        3'b011: gold = alu_a | alu_b;
        3'b100: gold = alu_a ^ alu_b;
        3'b101: gold = ~alu_a;
        3'b110: gold = {alu_a[WIDTH-2:0], 1'b0};
        3'b111: gold = {1'b0, alu_a[WIDTH-1:1]};
        default: gold = '0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state: one DRIVE/CHECK pair per vector
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_DRIVE;
      ST_DRIVE: state_nx = ST_CHECK;
      ST_CHECK: state_nx = last ? ST_DONE : ST_DRIVE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Vector sequencing, ALU drive and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_s   <= '0;
      alu_en  <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      err_vec <= '0;
      pair    <= '0;
      vec     <= '0;
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          alu_a  <= '0;
          alu_b  <= '0;
          alu_s  <= '0;
          alu_en <= 1'b0;
          if (start) begin
            err_cnt <= '0;
            err_vec <= '0;
            pass    <= 1'b0;
            pair    <= '0;
            vec     <= '0;
            op_a    <= A0;
            op_b    <= B0;
          end
        end
        ST_DRIVE: begin
          alu_a  <= op_a;
          alu_b  <= op_b;
          alu_s  <= vec[2:0];
          alu_en <= vec[3];
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
            if (err_cnt == 8'h00)
              err_vec <= {alu_a, alu_b, alu_s, alu_en};
          end
          vec <= vec + 4'd1;
          if (vec == 4'hf) begin
            pair <= pair + PW'(1);
            op_a <= op_a + WIDTH'(3);
            op_b <= op_b + WIDTH'(5);
          end
        end
        ST_DONE: begin
          done   <= 1'b1;
          pass   <= (err_cnt == 8'h00);
          alu_a  <= '0;
          alu_b  <= '0;
          alu_s  <= '0;
          alu_en <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist with behavioural ALUs,
// including faulty variants and a saturating long run.
module tb_alu_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  int          mode = 0;

  logic [3:0]  a1, b1, z1;
  logic [2:0]  s1;
  logic        en1, busy1, done1, pass1;
  logic [7:0]  cnt1;
  logic [11:0] ev1;

  logic [3:0]  a2, b2, z2;
  logic [2:0]  s2;
  logic        en2, busy2, done2, pass2;
  logic [7:0]  cnt2;
  logic [11:0] ev2;

  int checks = 0;
  int fails  = 0;
  int done_at, busy_cnt;

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_alu(
    input logic [3:0] a, input logic [3:0] b,
    input logic [2:0] s, input logic en);
    logic [3:0] r;
    r = 4'h0;
    if (en) begin
      case (s)
        3'd0: r = a + b;
        3'd1: r = a - b;
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = ~a;
        3'd6: r = a << 1;
        default: r = a >> 1;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    z1 = ref_alu(a1, b1, s1, en1);
    if (mode == 1 && en1 && s1 == 3'd1) z1 = a1 - b1 - 4'd1;
    if (mode == 2 && !en1) z1 = a1;
  end

  assign z2 = ~ref_alu(a2, b2, s2, en2);

  alu_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_a(a1), .alu_b(b1), .alu_s(s1), .alu_en(en1),
    .alu_z(z1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(cnt1), .err_vec(ev1)
  );

  alu_bist #(.NUM_PAIRS(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .alu_a(a2), .alu_b(b2), .alu_s(s2), .alu_en(en2),
    .alu_z(z2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(cnt2), .err_vec(ev2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int pulse_at, input int stop_at,
                     output int d_at, output int b_cnt);
    d_at  = 0;
    b_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (busy1) b_cnt++;
    for (int n = 1; n <= 300; n++) begin
      if (n == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (n == stop_at) return;
      if (done1) begin
        d_at = n;
        break;
      end
      if (busy1) b_cnt++;
    end
  endtask

  initial begin
    #12;
    chk("reset_outs", {busy1, done1, pass1, cnt1, ev1, a1, b1, s1, en1},
        32'h0);
    rst_n = 1'b1;

    mode = 0;
    run(0, 0, done_at, busy_cnt);
    chk("t1_done_at", done_at, 129);
    chk("t1_busy", busy_cnt, 128);
    chk("t1_pass", pass1, 1);
    chk("t1_cnt", cnt1, 0);
    chk("t1_vec", ev1, 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", done1, 0);
    chk("t1_idle_drv", {a1, b1, s1, en1}, 0);
    chk("t1_pass_hold", pass1, 1);

    mode = 1;
    run(0, 0, done_at, busy_cnt);
    chk("t2_done_at", done_at, 129);
    chk("t2_pass", pass1, 0);
    chk("t2_cnt", cnt1, 4);
    chk("t2_vec", ev1, 12'h953);

    mode = 2;
    run(0, 0, done_at, busy_cnt);
    chk("t3_cnt", cnt1, 32);
    chk("t3_vec", ev1, 12'h950);
    chk("t3_pass", pass1, 0);

    mode = 0;
    run(40, 0, done_at, busy_cnt);
    chk("t5_done_at", done_at, 129);
    chk("t5_busy", busy_cnt, 128);
    chk("t5_pass", pass1, 1);

    mode = 2;
    run(0, 50, done_at, busy_cnt);
    chk("t6_cnt_mid", cnt1, 16);
    chk("t6_busy_mid", busy1, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {busy1, done1, pass1, cnt1, ev1, a1, b1, s1, en1},
        32'h0);
    @(posedge clk); #1;
    chk("t6_no_done", done1, 0);
    rst_n = 1'b1;
    mode = 0;
    run(0, 0, done_at, busy_cnt);
    chk("t6_done_at", done_at, 129);
    chk("t6_pass", pass1, 1);
    chk("t6_cnt", cnt1, 0);

    done_at = 0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int n = 1; n <= 700; n++) begin
      @(posedge clk); #1;
      if (done2) begin
        done_at = n;
        break;
      end
    end
    chk("t4_done_at", done_at, 641);
    chk("t4_cnt_sat", cnt2, 255);
    chk("t4_pass", pass2, 0);
    chk("t4_vec", ev2, 12'h950);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
